// File: rtl/apb_conv_pkg.sv
// ---------------------------------------------------------------------------
// apb_conv_pkg
// Shared types and constants for the APB master converter.
//   ADDR_W / DATA_W   : fixed 8-bit address and data widths
//   TIMEOUT_CYCLES    : ACCESS cycles without pready before a forced end
//                       (only used when APB_CONV_TIMEOUT_EN is defined)
//   state_e           : converter FSM states
// ---------------------------------------------------------------------------
package apb_conv_pkg;

  localparam int ADDR_W         = 8;
  localparam int DATA_W         = 8;
  localparam int TIMEOUT_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_DONE    = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

endpackage : apb_conv_pkg

// File: rtl/apb_conv_req_arb.sv
// ---------------------------------------------------------------------------
// apb_conv_req_arb
// Combinational selection between the local write and read commands.
// A pending write always wins over a pending read.
// Ports:
//   write_req_i / write_addr_i / write_data_i : write command
//   read_req_i  / read_addr_i                 : read command
//   req_valid_o : at least one command is pending
//   addr_o      : address of the selected command
//   data_o      : write data (meaningful only when write_o is 1)
//   write_o     : 1 = selected command is a write
// ---------------------------------------------------------------------------
module apb_conv_req_arb
  import apb_conv_pkg::*;
(
  input  logic              write_req_i,
  input  logic [ADDR_W-1:0] write_addr_i,
  input  logic [DATA_W-1:0] write_data_i,
  input  logic              read_req_i,
  input  logic [ADDR_W-1:0] read_addr_i,
  output logic              req_valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              write_o
);

  // Write-over-read priority select.
  always_comb begin
    req_valid_o = write_req_i | read_req_i;
    data_o      = write_data_i;
    if (write_req_i) begin
      addr_o  = write_addr_i;
      write_o = 1'b1;
    end else begin
      addr_o  = read_addr_i;
      write_o = 1'b0;
    end
  end

endmodule : apb_conv_req_arb

// File: rtl/apb_master_converter.sv
// ---------------------------------------------------------------------------
// apb_master_converter
// Turns level request/acknowledge read and write commands into single APB
// (AMBA 3) transfers toward one 8-bit slave. One transfer at a time; slave
// wait states are honoured through pready; each completed command returns
// a one-cycle ack.
//
// Optional feature macro: APB_CONV_TIMEOUT_EN
//   When defined, adds output timeout_err and a 4-bit wait counter. An ACCESS
//   phase lasting TIMEOUT_CYCLES cycles without pready is ended with a normal
//   ack, read_data = 8'h00 for reads, and a timeout_err pulse with the ack.
//
// Ports:
//   pclk, preset                   : clock, synchronous active-high reset
//   write_req/addr/data, write_ack : local write command and completion
//   read_req/addr, read_data/ack   : local read command, data and completion
//   paddr, pwrite, psel, penable,
//   pwdata                         : APB master outputs (all registered)
//   prdata, pready                 : APB slave responses
//   timeout_err                    : (optional) ACCESS timeout pulse
// ---------------------------------------------------------------------------
module apb_master_converter
  import apb_conv_pkg::*;
(
  input  logic              pclk,
  input  logic              preset,
  input  logic              write_req,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic              write_ack,
  input  logic              read_req,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] read_data,
  output logic              read_ack,
`ifdef APB_CONV_TIMEOUT_EN
  output logic              timeout_err,
`endif
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  state_e            state_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              pwrite_q;
  logic              psel_q;
  logic              penable_q;
  logic              write_ack_q;
  logic              read_ack_q;
  logic [DATA_W-1:0] read_data_q;

  logic              req_valid_d;
  logic [ADDR_W-1:0] sel_addr_d;
  logic [DATA_W-1:0] sel_data_d;
  logic              sel_write_d;
  logic              served_req_d;

`ifdef APB_CONV_TIMEOUT_EN
  localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT_CYCLES - 1);
  logic [3:0] wait_cnt_q;
  logic       timeout_err_q;
`endif

  apb_conv_req_arb u_req_arb (
    .write_req_i  (write_req),
    .write_addr_i (write_addr),
    .write_data_i (write_data),
    .read_req_i   (read_req),
    .read_addr_i  (read_addr),
    .req_valid_o  (req_valid_d),
    .addr_o       (sel_addr_d),
    .data_o       (sel_data_d),
    .write_o      (sel_write_d)
  );

  // Level of the request that started the current transfer; pwrite_q still
  // holds its direction because it only changes when a new transfer latches.
  always_comb begin
    if (pwrite_q) begin
      served_req_d = write_req;
    end else begin
      served_req_d = read_req;
    end
  end

  // Converter FSM with all APB and handshake outputs registered.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      paddr_q     <= 8'h00;
      pwdata_q    <= 8'h00;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      write_ack_q <= 1'b0;
      read_ack_q  <= 1'b0;
      read_data_q <= 8'h00;
`ifdef APB_CONV_TIMEOUT_EN
      wait_cnt_q    <= 4'd0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          write_ack_q <= 1'b0;
          read_ack_q  <= 1'b0;
          if (req_valid_d) begin
            paddr_q  <= sel_addr_d;
            pwrite_q <= sel_write_d;
            // Reads leave the last write data on pwdata.
            if (sel_write_d) begin
              pwdata_q <= sel_data_d;
            end
            psel_q  <= 1'b1;
            state_q <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          penable_q <= 1'b1;
`ifdef APB_CONV_TIMEOUT_EN
          wait_cnt_q <= 4'd0;
`endif
          state_q <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (pready) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            if (pwrite_q) begin
              write_ack_q <= 1'b1;
            end else begin
              read_ack_q  <= 1'b1;
              read_data_q <= prdata;
            end
            state_q <= ST_DONE;
          end
`ifdef APB_CONV_TIMEOUT_EN
          else if (wait_cnt_q == TIMEOUT_LAST) begin
            // Forced completion: normal ack, zero read data, error flag.
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            timeout_err_q <= 1'b1;
            if (pwrite_q) begin
              write_ack_q <= 1'b1;
            end else begin
              read_ack_q  <= 1'b1;
              read_data_q <= 8'h00;
            end
            state_q <= ST_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
`endif
        end

        ST_DONE: begin
          write_ack_q <= 1'b0;
          read_ack_q  <= 1'b0;
`ifdef APB_CONV_TIMEOUT_EN
          timeout_err_q <= 1'b0;
`endif
          state_q <= ST_RELEASE;
        end

        ST_RELEASE: begin
          // A request still held after its ack must not start a new transfer.
          if (!served_req_d) begin
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
          write_ack_q <= 1'b0;
          read_ack_q  <= 1'b0;
        end
      endcase
    end
  end

  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pwrite    = pwrite_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign write_ack = write_ack_q;
  assign read_ack  = read_ack_q;
  assign read_data = read_data_q;
`ifdef APB_CONV_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`endif

endmodule : apb_master_converter

// File: tb/tb_apb_master_converter.sv
`timescale 1ns/1ps
module tb_apb_master_converter;

  logic       pclk = 1'b0;
  logic       preset;
  logic       write_req, read_req;
  logic [7:0] write_addr, write_data, read_addr;
  logic       write_ack, read_ack;
  logic [7:0] read_data;
  logic [7:0] paddr, pwdata, prdata;
  logic       pwrite, psel, penable, pready;
`ifdef APB_CONV_TIMEOUT_EN
  logic       timeout_err;
`endif

  always #5 pclk = ~pclk;

  apb_master_converter dut (
    .pclk       (pclk),
    .preset     (preset),
    .write_req  (write_req),
    .write_addr (write_addr),
    .write_data (write_data),
    .write_ack  (write_ack),
    .read_req   (read_req),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .read_ack   (read_ack),
`ifdef APB_CONV_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .paddr      (paddr),
    .pwrite     (pwrite),
    .psel       (psel),
    .penable    (penable),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready)
  );

  // Expected outcome of one command, pushed at issue time.
  typedef struct {
    bit         is_write;
    logic [7:0] addr;
    logic [7:0] data;       // write data, or expected read_data
    logic [7:0] pwdata;     // pwdata expected on the bus at ack
    int         pen_cycles; // cycles penable is high
    bit         timeout;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] ref_mem[256];   // reference register bank
  logic [7:0] slave_mem[256]; // register bank inside the slave model
  logic [7:0] last_wdata;
  int         next_waits = 0;
  int         xfer_cnt = 0;
  int         exp_xfers = 0;

  task automatic check_val(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // APB slave model: register bank with a programmable number of wait states.
  initial begin : slave
    int wait_left;
    wait_left = 0;
    pready = 1'b0;
    prdata = 8'h00;
    forever begin
      @(negedge pclk);
      if (psel && !penable) begin
        wait_left = next_waits;
        pready = 1'b0;
      end else if (psel && penable) begin
        if (wait_left == 0) begin
          pready = 1'b1;
          prdata = slave_mem[paddr];
          if (pwrite) slave_mem[paddr] = pwdata;
          xfer_cnt++;
        end else begin
          wait_left--;
          pready = 1'b0;
        end
      end else begin
        pready = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on each ack and checks the bus state.
  initial begin : monitor
    exp_t e;
    int   pen_cnt;
    bit   prev_ack;
    pen_cnt = 0;
    prev_ack = 1'b0;
    forever begin
      @(negedge pclk);
      if (prev_ack) check_val("ack_one_cycle", int'(write_ack | read_ack), 0);
      if (write_ack || read_ack) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_ack", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_val("ack_kind", int'(write_ack), int'(e.is_write));
          check_val("paddr_at_ack", int'(paddr), int'(e.addr));
          check_val("pwrite_at_ack", int'(pwrite), int'(e.is_write));
          check_val("pwdata_at_ack", int'(pwdata), int'(e.pwdata));
          if (!e.is_write) check_val("read_data_at_ack", int'(read_data), int'(e.data));
          check_val("penable_cycles", pen_cnt, e.pen_cycles);
          check_val("psel_low_at_ack", int'(psel | penable), 0);
`ifdef APB_CONV_TIMEOUT_EN
          check_val("timeout_err", int'(timeout_err), int'(e.timeout));
`endif
        end
      end
      if (penable) begin
        check_val("penable_implies_psel", int'(psel), 1);
        pen_cnt++;
      end else if (!psel) begin
        pen_cnt = 0;
      end
      prev_ack = write_ack | read_ack;
    end
  end

  task automatic do_reset();
    preset = 1'b1;
    write_req = 1'b0;
    read_req = 1'b0;
    repeat (3) @(negedge pclk);
    check_val("reset_psel", int'(psel), 0);
    check_val("reset_penable", int'(penable), 0);
    check_val("reset_pwrite", int'(pwrite), 0);
    check_val("reset_acks", int'(write_ack | read_ack), 0);
    check_val("reset_paddr", int'(paddr), 0);
    check_val("reset_pwdata", int'(pwdata), 0);
    check_val("reset_read_data", int'(read_data), 0);
    preset = 1'b0;
    last_wdata = 8'h00;
    @(negedge pclk);
  endtask

  // Issue one command, wait for its ack, hold the request `hold` extra cycles.
  task automatic do_cmd(bit wr, logic [7:0] a, logic [7:0] d, int waits, int hold);
    exp_t e;
    int   lat;
    bit   got;
    bit   to;
    to = (waits >= 16);
    e.is_write = wr;
    e.addr = a;
    e.timeout = to;
    e.pen_cycles = to ? 16 : waits + 1;
    if (wr) begin
      last_wdata = d;
      e.data = d;
      if (!to) ref_mem[a] = d;
    end else begin
      e.data = to ? 8'h00 : ref_mem[a];
    end
    e.pwdata = last_wdata;
    if (!to) exp_xfers++;
    exp_q.push_back(e);
    next_waits = waits;
    if (wr) begin
      write_req = 1'b1; write_addr = a; write_data = d;
    end else begin
      read_req = 1'b1; read_addr = a;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(negedge pclk);
      lat++;
      got = wr ? write_ack : read_ack;
    end
    check_val("ack_latency", got ? lat : -1, to ? 18 : waits + 3);
    repeat (hold) @(negedge pclk);
    write_req = 1'b0;
    read_req = 1'b0;
    repeat (2) @(negedge pclk);
    if (!wr) check_val("read_data_held", int'(read_data), int'(e.data));
  endtask

  // Write and read requested together: write first, read after write drops.
  task automatic do_dual(logic [7:0] wa, logic [7:0] wd, logic [7:0] ra);
    exp_t ew, er;
    int   n;
    ew.is_write = 1'b1; ew.addr = wa; ew.data = wd; ew.pwdata = wd;
    ew.pen_cycles = 2; ew.timeout = 1'b0;
    last_wdata = wd;
    ref_mem[wa] = wd;
    er.is_write = 1'b0; er.addr = ra; er.data = ref_mem[ra]; er.pwdata = wd;
    er.pen_cycles = 2; er.timeout = 1'b0;
    exp_q.push_back(ew);
    exp_q.push_back(er);
    exp_xfers += 2;
    next_waits = 1;
    write_req = 1'b1; write_addr = wa; write_data = wd;
    read_req = 1'b1; read_addr = ra;
    n = 0;
    while (!write_ack && n < 100) begin @(negedge pclk); n++; end
    check_val("dual_write_ack", int'(write_ack), 1);
    write_req = 1'b0;
    n = 0;
    while (!read_ack && n < 100) begin @(negedge pclk); n++; end
    check_val("dual_read_ack", int'(read_ack), 1);
    read_req = 1'b0;
    repeat (2) @(negedge pclk);
  endtask

  // Reset while the slave is stalling ACCESS: transfer abandoned, no ack.
  task automatic do_reset_mid();
    int n;
    next_waits = 6;
    write_req = 1'b1; write_addr = 8'h77; write_data = 8'h12;
    n = 0;
    while (!penable && n < 20) begin @(negedge pclk); n++; end
    check_val("reached_access", int'(penable), 1);
    preset = 1'b1;
    write_req = 1'b0;
    @(negedge pclk);
    check_val("midreset_psel", int'(psel), 0);
    check_val("midreset_penable", int'(penable), 0);
    check_val("midreset_acks", int'(write_ack | read_ack), 0);
    check_val("midreset_paddr", int'(paddr), 0);
    check_val("midreset_pwdata", int'(pwdata), 0);
    preset = 1'b0;
    last_wdata = 8'h00;
    repeat (4) @(negedge pclk);
  endtask

  initial begin : stimulus
    bit         wr;
    logic [7:0] a, d;
    int         waits;
    write_addr = 8'h00; write_data = 8'h00; read_addr = 8'h00;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'(i) ^ 8'hAA;
      slave_mem[i] = 8'(i) ^ 8'hAA;
    end
    do_reset();

    do_cmd(1'b1, 8'hCC, 8'hAC, 0, 0);
    do_cmd(1'b1, 8'hF5, 8'h50, 0, 2);
    do_cmd(1'b0, 8'h55, 8'h00, 0, 0);   // bank holds 8'hFF at 8'h55
    do_cmd(1'b0, 8'hCC, 8'h00, 3, 1);
    do_cmd(1'b1, 8'h10, 8'h3E, 3, 0);
    do_dual(8'h21, 8'h9D, 8'h21);
    do_reset_mid();

    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      d = 8'($urandom);
      waits = $urandom_range(0, 3);
`ifdef APB_CONV_TIMEOUT_EN
      if ($urandom_range(0, 7) == 0) waits = 20;
`endif
      do_cmd(wr, a, d, waits, $urandom_range(0, 2));
    end

`ifdef APB_CONV_TIMEOUT_EN
    do_cmd(1'b0, 8'h3C, 8'h00, 30, 0);
    do_cmd(1'b1, 8'h3C, 8'h66, 30, 1);
`endif

    repeat (5) @(negedge pclk);
    check_val("apb_transfer_count", xfer_cnt, exp_xfers);
    check_val("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_apb_master_converter
